// File: rtl/spdif_sample_fifo.sv
// spdif_sample_fifo: primed stereo sample FIFO with underrun handling, mute and underrun stats for the S/PDIF transmitter
module spdif_sample_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter bit HOLD_ON_EMPTY = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [15:0]           in_l_i,
  input  logic [15:0]           in_r_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  sample_req_i,
  input  logic                  mute_i,
  output logic [15:0]           audio_l_o,
  output logic [15:0]           audio_r_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  running_o,
  output logic                  underrun_o,
  output logic [15:0]           underrun_cnt_o,
  input  logic                  clr_stats_i
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] HALF = {2'b01, {(DEPTH_LOG2-1){1'b0}}};
  typedef enum logic {FILL, RUN} state_t;
  state_t state_q, state_d;
  logic [31:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0] level_q;
  logic push, pop, urun;
  assign in_ready_o = level_q != FULL;
  assign push = in_valid_i && in_ready_o;
  assign pop = state_q == RUN && sample_req_i && level_q != '0;
  assign urun = state_q == RUN && sample_req_i && level_q == '0;
  assign level_o = level_q;
  assign running_o = state_q == RUN;
  always_comb begin
    state_d = state_q;
    state_d = state_q == FILL ? (level_q >= HALF ? RUN : FILL) : (urun ? FILL : RUN);
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q] <= {in_r_i, in_l_i};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL;
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      audio_l_o <= '0;
      audio_r_o <= '0;
      underrun_o <= 1'b0;
      underrun_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_q + DEPTH_LOG2'(push);
      rptr_q <= rptr_q + DEPTH_LOG2'(pop);
      level_q <= level_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
      if (pop) {audio_r_o, audio_l_o} <= mute_i ? 32'd0 : mem[rptr_q];
      else if (sample_req_i && !HOLD_ON_EMPTY) {audio_r_o, audio_l_o} <= 32'd0;
      underrun_o <= urun;
      underrun_cnt_o <= clr_stats_i ? 16'd0 : (urun && underrun_cnt_o != 16'hFFFF) ? underrun_cnt_o + 16'd1 : underrun_cnt_o;
    end
  end
endmodule

// File: tb/tb_spdif_sample_fifo.sv
// tb_spdif_sample_fifo: queue-model scoreboard bench driving HOLD_ON_EMPTY=1 and =0 instances in lockstep
module tb_spdif_sample_fifo;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst, in_valid, sample_req, mute, clr_stats;
  logic [15:0] in_l, in_r;
  logic h_rdy, h_run, h_ur, z_rdy, z_run, z_ur;
  logic [15:0] h_l, h_r, h_cnt, z_l, z_r, z_cnt;
  logic [4:0] h_lvl, z_lvl;
  typedef struct {
    logic [15:0] hl, hr, zl, zr, cnt;
    logic [4:0] lvl;
    logic run, ur, rdy;
  } exp_t;
  exp_t exp_q[$];
  logic [31:0] mq[$];
  logic m_run;
  logic [15:0] m_hl, m_hr, m_zl, m_zr, m_cnt;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  spdif_sample_fifo #(.DEPTH_LOG2(4), .HOLD_ON_EMPTY(1'b1)) dut_h (
    .clk_i(clk), .rst_i(rst), .in_l_i(in_l), .in_r_i(in_r), .in_valid_i(in_valid),
    .in_ready_o(h_rdy), .sample_req_i(sample_req), .mute_i(mute), .audio_l_o(h_l),
    .audio_r_o(h_r), .level_o(h_lvl), .running_o(h_run), .underrun_o(h_ur),
    .underrun_cnt_o(h_cnt), .clr_stats_i(clr_stats));
  spdif_sample_fifo #(.DEPTH_LOG2(4), .HOLD_ON_EMPTY(1'b0)) dut_z (
    .clk_i(clk), .rst_i(rst), .in_l_i(in_l), .in_r_i(in_r), .in_valid_i(in_valid),
    .in_ready_o(z_rdy), .sample_req_i(sample_req), .mute_i(mute), .audio_l_o(z_l),
    .audio_r_o(z_r), .level_o(z_lvl), .running_o(z_run), .underrun_o(z_ur),
    .underrun_cnt_o(z_cnt), .clr_stats_i(clr_stats));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input logic v, input logic [15:0] l, input logic [15:0] r,
                      input logic rq, input logic mu, input logic cl, input logic rs);
    logic do_push, urun, next_run;
    logic [31:0] d;
    exp_t e;
    @(negedge clk);
    in_valid = v; in_l = l; in_r = r; sample_req = rq; mute = mu; clr_stats = cl; rst = rs;
    urun = 1'b0;
    if (rs) begin
      mq.delete();
      m_run = 1'b0;
      {m_hl, m_hr, m_zl, m_zr, m_cnt} = '0;
    end else begin
      do_push = v && mq.size() < DEPTH;
      urun = rq && m_run && mq.size() == 0;
      next_run = m_run ? !urun : mq.size() >= DEPTH / 2;
      if (rq && m_run && mq.size() > 0) begin
        d = mq.pop_front();
        if (mu) d = '0;
        {m_hr, m_hl} = d;
        {m_zr, m_zl} = d;
      end else if (rq) begin
        m_zl = '0;
        m_zr = '0;
      end
      if (do_push) mq.push_back({r, l});
      if (cl) m_cnt = '0;
      else if (urun && m_cnt != 16'hFFFF) m_cnt++;
      m_run = next_run;
    end
    e.hl = m_hl; e.hr = m_hr; e.zl = m_zl; e.zr = m_zr; e.cnt = m_cnt;
    e.lvl = 5'(mq.size()); e.run = m_run; e.ur = urun; e.rdy = mq.size() != DEPTH;
    exp_q.push_back(e);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic cycle_underrun(input logic cl);
    for (int i = 0; i < 8; i++) step(1, 16'($urandom), 16'($urandom), 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, cl, 0);
    idle(1);
  endtask
  task automatic preset_cnt(input logic [15:0] v);
    force dut_h.underrun_cnt_o = v;
    force dut_z.underrun_cnt_o = v;
    #1;
    release dut_h.underrun_cnt_o;
    release dut_z.underrun_cnt_o;
    m_cnt = v;
    exp_q[$].cnt = v;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("audio_hold", {h_r, h_l}, {e.hr, e.hl});
        chk("audio_zero", {z_r, z_l}, {e.zr, e.zl});
        chk("level", {h_lvl, z_lvl}, {e.lvl, e.lvl});
        chk("ready", {h_rdy, z_rdy}, {e.rdy, e.rdy});
        chk("running", {h_run, z_run}, {e.run, e.run});
        chk("underrun", {h_ur, z_ur}, {e.ur, e.ur});
        chk("underrun_cnt", {h_cnt, z_cnt}, {e.cnt, e.cnt});
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    logic v, rq;
    int pv, pr;
    {rst, in_valid, sample_req, mute, clr_stats, in_l, in_r} = '0;
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    for (int i = 1; i <= 7; i++) step(1, 16'(i), 16'(16'h8000 + i), 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 0, 0, 0);
    idle(2);
    step(1, 16'h0008, 16'h8008, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 1, 0, 0, 0);
      idle(63);
    end
    for (int i = 0; i < DEPTH; i++) step(1, 16'($urandom), 16'($urandom), 0, 0, 0, 0);
    step(1, 16'h1234, 16'h5678, 0, 0, 0, 0);
    step(1, 16'h1234, 16'h5678, 0, 0, 0, 0);
    step(1, 16'h1234, 16'h5678, 1, 0, 0, 0);
    step(1, 16'h1234, 16'h5678, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 1, 0, 0);
    idle(2);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(1);
    preset_cnt(16'hFFFE);
    cycle_underrun(1'b0);
    cycle_underrun(1'b0);
    cycle_underrun(1'b0);
    cycle_underrun(1'b1);
    cycle_underrun(1'b0);
    for (int i = 0; i < 12; i++) step(1, 16'($urandom), 16'($urandom), 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 20; i++) step(1, 16'($urandom), 16'($urandom), 1, 0, 0, 0);
    step(1, 16'($urandom), 16'($urandom), 1, 0, 0, 1);
    idle(2);
    for (int i = 0; i < 4000; i++) begin
      pv = (i / 250) % 2 ? 35 : 75;
      pr = (i / 250) % 2 ? 75 : 35;
      v = $urandom_range(0, 99) < pv;
      rq = $urandom_range(0, 99) < pr;
      step(v, 16'($urandom), 16'($urandom), rq, $urandom_range(0, 9) == 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 599) == 0);
    end
    idle(3);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spdif_sample_fifo.md
# spdif_sample_fifo

Stereo 16-bit sample buffer that sits directly upstream of the S/PDIF transmitter. It accepts L/R sample pairs from the core audio mixer at the mixer's rate through a valid/ready handshake. On each single-cycle sample request from the transmitter it pops one pair and holds it on its outputs, which decouples the mixer's rate jitter from the transmitter's fixed frame rate. The block adds pre-fill priming, defined underrun behaviour, mute, and a saturating underrun counter.

## Interface
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 sample pairs (default 16).
- HOLD_ON_EMPTY, 1: on an unserved request, 1 repeats the last output pair and 0 outputs zero.
- clk_i  in  1  single system clock; all logic on posedge.
- rst_i  in  1  reset, synchronous, active-high.
- in_l_i  in  16  left sample, two's complement.
- in_r_i  in  16  right sample, two's complement.
- in_valid_i  in  1  mixer presents a pair.
- in_ready_o  out  1  buffer can accept; transfer occurs when in_valid_i && in_ready_o.
- sample_req_i  in  1  single-cycle pop request, driven by the transmitter's sample_req_o.
- mute_i  in  1  served pops output zero while high.
- audio_l_o  out  16  held left sample to the transmitter.
- audio_r_o  out  16  held right sample to the transmitter.
- level_o  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
- running_o  out  1  high in RUN state.
- underrun_o  out  1  one-cycle pulse on an underrun.
- underrun_cnt_o  out  16  saturating underrun count.
- clr_stats_i  in  1  clears underrun_cnt_o.

## Operation
- Storage: circular RAM of 2^DEPTH_LOG2 x 32 bits ({R,L}). Write and read pointers are DEPTH_LOG2 bits and wrap naturally; level is a separate DEPTH_LOG2+1-bit register.
- in_ready_o = (level != 2^DEPTH_LOG2). It is decoded from the registered level, so there is no combinational path from sample_req_i.
- Push: on in_valid_i && in_ready_o, write the pair at wptr and increment wptr.
- States:
  - FILL (reset state): requests are never served from the RAM. Outputs follow HOLD_ON_EMPTY. No underrun is counted.
  - FILL -> RUN when the registered level >= 2^(DEPTH_LOG2-1).
  - RUN: on sample_req_i with level > 0, read at rptr, increment rptr, and register the pair to the outputs (zero if mute_i).
  - RUN with sample_req_i and level == 0 (pre-update value): underrun. Pulse underrun_o, increment underrun_cnt_o unless it is at 16'hFFFF, apply HOLD_ON_EMPTY to the outputs, and go to FILL.
- Level update: level_next = level + push - pop. Push and pop in the same cycle leave level unchanged.
- Pop decision uses the pre-update level. A push and a request in the same cycle at level 0 is an underrun; the pushed pair is retained.
- When the FIFO is full, in_ready_o is 0, so no push occurs and a pop proceeds normally.
- mute_i affects output data only. Pointers, level and state behave as if unmuted.
- clr_stats_i zeroes underrun_cnt_o next cycle. If an underrun occurs in the same cycle, clear wins: the count becomes 0. underrun_o still pulses.
- Reset (also mid-operation) returns the block to the reset state:
  - pointers, level, and audio_l_o/audio_r_o = 0;
  - state = FILL, running_o = 0;
  - underrun_o = 0, underrun_cnt_o = 0;
  - in_ready_o = 1 from the first cycle after rst_i falls;
  - any in-flight data is discarded.

## Timing
- Push-to-level: level_o reflects a push one cycle after the handshake cycle.
- Request-to-output latency: audio_l_o/audio_r_o update exactly 1 cycle after the sample_req_i cycle. This fits because the transmitter consumes the pair at its next subframe load, which is at least 64 bit-enables later.
- Outputs hold their value between requests.
- FILL -> RUN: running_o rises 1 cycle after the level reaches the threshold. A request in that same cycle is still treated as a FILL request.
- The underrun_o pulse and the FILL transition take effect 1 cycle after the offending request.
- RAM read is registered. If an inferred-RAM read needs two cycles, data is prefetched into an output-stage register so the 1-cycle latency still holds.
- Maximum throughput is one push and one pop per cycle.

## Test plan
- Reset/prime: after reset, push 7 pairs (DEPTH_LOG2=4) then issue a request. Required: running_o=0, outputs stay 0, no underrun. Push an 8th pair; running_o=1 two cycles after that push.
- Ordered drain: prime with pairs L=16'h0001..0008 and R=16'h8001..8008, then issue 8 requests spaced 64 cycles apart. Required: outputs step through 0001/8001 .. 0008/8008, each 1 cycle after its request, and level_o counts 8 down to 0.
- Underrun: issue a 9th request at level 0. Required:
  - underrun_o pulses once and underrun_cnt_o=1;
  - HOLD_ON_EMPTY=1: outputs keep 0008/8008; HOLD_ON_EMPTY=0: outputs become 0;
  - running_o drops.
- Full/simultaneous: fill to 16. Required: in_ready_o=0 and held in_valid_i data is not lost. Issue a request with valid still held: the pop occurs, in_ready_o=1 next cycle, the held pair is accepted, and level returns to 16.
- Mute and stats: with mute_i=1, a served request outputs 0/0 and level still decrements. Force 65537 underruns: underrun_cnt_o saturates at 16'hFFFF. clr_stats_i plus an underrun in the same cycle: count = 0.
- Mid-operation reset: assert rst_i for 1 cycle during back-to-back push and pop traffic. Required: next cycle level_o=0, outputs 0, FILL state, and in_ready_o=1.
